// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the writeback-port arbiter.
//   REG_AW / REG_DW : register address and data widths
//   ZERO_REG        : architectural zero register (writes to it are dropped)
//   pend_entry_t    : one pending multi-cycle write {valid, rd, data}
//   rd_onehot()     : one-hot decode of a register address
package wb_write_arbiter_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [REG_DW-1:0] data;
    } pend_entry_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-write FIFO for multi-cycle unit results.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   push_i, push_rd_i,
//   push_data_i           : enqueue a valid entry at the write pointer
//   pop_i                 : retire the head entry (valid or squashed)
//   squash_i, squash_rd_i : clear valid on every entry whose rd matches
//   head_o                : entry at the read pointer
//   empty_o, full_o       : occupancy flags from registered count
//   busy_mask_o           : OR of one-hot(rd) over all valid entries
module wb_pend_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [REG_AW-1:0]   push_rd_i,
    input  logic [REG_DW-1:0]   push_data_i,
    input  logic                pop_i,
    input  logic                squash_i,
    input  logic [REG_AW-1:0]   squash_rd_i,
    output pend_entry_t         head_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [NUM_REGS-1:0] busy_mask_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    pend_entry_t        mem_q [DEPTH];
    pend_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

    // Next state: squash first, then pop and push (never the same slot while
    // pushing is allowed, since push only happens when not full).
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (squash_i && mem_q[i].valid && (mem_q[i].rd == squash_rd_i)) begin
                mem_d[i].valid = 1'b0;
            end
        end

        if (pop_i) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d              = rd_ptr_q + PTR_W'(1);
        end

        if (push_i) begin
            mem_d[wr_ptr_q] = '{valid: 1'b1, rd: push_rd_i, data: push_data_i};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Hazard mask from registered entries only.
    always_comb begin
        busy_mask_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem_q[i].valid) begin
                busy_mask_o = busy_mask_o | rd_onehot(mem_q[i].rd);
            end
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: the writeback stage always wins, the
// multi-cycle unit's results wait in a small pending FIFO.
// Optional starvation guard: define WB_STARVE_GUARD_EN to build the counter
// that raises PipeStall; otherwise PipeStall is tied low.
// Ports:
//   RegClk, Reset                 : clock, synchronous active-high reset
//   WBRd, WBData, WBRegWrite      : writeback-stage write request
//   MDValid, MDRd, MDData/MDReady : multi-cycle unit valid/ready handshake
//   RFWrEn, RFWrAddr, RFWrData    : registered register-file write
//   BusyMask                      : registers with pending buffered writes
//   PipeStall                     : registered pipeline freeze request
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                RegClk,
    input  logic                Reset,
    input  logic [REG_AW-1:0]   WBRd,
    input  logic [REG_DW-1:0]   WBData,
    input  logic                WBRegWrite,
    input  logic                MDValid,
    input  logic [REG_AW-1:0]   MDRd,
    input  logic [REG_DW-1:0]   MDData,
    output logic                MDReady,
    output logic                RFWrEn,
    output logic [REG_AW-1:0]   RFWrAddr,
    output logic [REG_DW-1:0]   RFWrData,
    output logic [NUM_REGS-1:0] BusyMask,
    output logic                PipeStall
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_write_arbiter: DEPTH must be a power of two >= 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("wb_write_arbiter: STARVE_LIMIT must be >= 1");
    end

    pend_entry_t        head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               wb_live;
    logic               md_accept;
    logic               md_push;
    logic               fifo_pop;
    logic               buf_grant;

    logic               alive_q;
    logic               wr_en_q, wr_en_d;
    logic [REG_AW-1:0]  wr_addr_q, wr_addr_d;
    logic [REG_DW-1:0]  wr_data_q, wr_data_d;

    // alive_q keeps MDReady low for the reset cycle and the one after it.
    assign MDReady   = alive_q && !fifo_full;
    assign wb_live   = WBRegWrite && (WBRd != ZERO_REG);
    assign md_accept = MDValid && MDReady;
    assign md_push   = md_accept && (MDRd != ZERO_REG);
    assign fifo_pop  = !fifo_empty && !wb_live;
    assign buf_grant = fifo_pop && head.valid;

    wb_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (RegClk),
        .rst_i       (Reset),
        .push_i      (md_push),
        .push_rd_i   (MDRd),
        .push_data_i (MDData),
        .pop_i       (fifo_pop),
        .squash_i    (wb_live),
        .squash_rd_i (WBRd),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .busy_mask_o (BusyMask)
    );

    // Grant mux: WB first, then a valid head; a squashed head pops silently.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (wb_live) begin
            wr_en_d   = 1'b1;
            wr_addr_d = WBRd;
            wr_data_d = WBData;
        end else if (buf_grant) begin
            wr_en_d   = 1'b1;
            wr_addr_d = head.rd;
            wr_data_d = head.data;
        end
    end

    always_ff @(posedge RegClk) begin
        if (Reset) begin
            alive_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            alive_q   <= 1'b1;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign RFWrEn   = wr_en_q;
    assign RFWrAddr = wr_addr_q;
    assign RFWrData = wr_data_q;

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    logic [STV_W-1:0] starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             md_wrote_q;

    // Counts cycles a valid head loses to WB; saturates at the limit. A
    // squashed head also clears it so a stall never waits on a dead entry.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || !head.valid || buf_grant) begin
            starve_d = '0;
        end else if (wb_live && (starve_q < STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end

        stall_d = stall_q;
        if (starve_q >= STV_W'(STARVE_LIMIT)) begin
            stall_d = 1'b1;
        end else if (stall_q && (md_wrote_q || !head.valid)) begin
            stall_d = 1'b0;
        end
    end

    always_ff @(posedge RegClk) begin
        if (Reset) begin
            starve_q   <= '0;
            stall_q    <= 1'b0;
            md_wrote_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            md_wrote_q <= buf_grant;
        end
    end

    assign PipeStall = stall_q;
`else
    assign PipeStall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter with a write scoreboard.
module tb_wb_write_arbiter;

`ifdef WB_STARVE_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    logic        RegClk = 1'b0;
    logic        Reset;
    logic [4:0]  WBRd;
    logic [31:0] WBData;
    logic        WBRegWrite;
    logic        MDValid;
    logic [4:0]  MDRd;
    logic [31:0] MDData;
    logic        MDReady;
    logic        RFWrEn;
    logic [4:0]  RFWrAddr;
    logic [31:0] RFWrData;
    logic [31:0] BusyMask;
    logic        PipeStall;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    wb_write_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .RegClk     (RegClk),
        .Reset      (Reset),
        .WBRd       (WBRd),
        .WBData     (WBData),
        .WBRegWrite (WBRegWrite),
        .MDValid    (MDValid),
        .MDRd       (MDRd),
        .MDData     (MDData),
        .MDReady    (MDReady),
        .RFWrEn     (RFWrEn),
        .RFWrAddr   (RFWrAddr),
        .RFWrData   (RFWrData),
        .BusyMask   (BusyMask),
        .PipeStall  (PipeStall)
    );

    always #5 RegClk = ~RegClk;

    // Scoreboard monitor: every presented write must match the oldest expected one.
    always @(negedge RegClk) begin
        if (RFWrEn === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_write: unexpected write rd=%0d data=0x%08h", RFWrAddr, RFWrData);
            end else begin
                e = exp_q.pop_front();
                if (RFWrAddr !== e.rd || RFWrData !== e.data) begin
                    errors++;
                    $display("FAIL rf_write: got rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                             RFWrAddr, RFWrData, e.rd, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge RegClk);
        #1;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        WBRegWrite = en;
        WBRd       = rd;
        WBData     = data;
    endtask

    task automatic set_md(input logic v, input logic [4:0] rd, input logic [31:0] data);
        MDValid = v;
        MDRd    = rd;
        MDData  = data;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    initial begin
        Reset = 1'b1;
        set_wb(1'b0, 5'd0, 32'h0);
        set_md(1'b0, 5'd0, 32'h0);

        // Reset state
        tick();
        tick();
        check("rst_wren",   32'(RFWrEn),    32'h0);
        check("rst_addr",   32'(RFWrAddr),  32'h0);
        check("rst_data",   RFWrData,       32'h0);
        check("rst_busy",   BusyMask,       32'h0);
        check("rst_stall",  32'(PipeStall), 32'h0);
        check("rst_ready",  32'(MDReady),   32'h0);
        Reset = 1'b0;
        tick();
        check("ready_after_rst", 32'(MDReady), 32'h1);

        // WB only, then a zero-register request
        set_wb(1'b1, 5'd5, 32'hDEADBEEF);
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        check("wb_wren", 32'(RFWrEn), 32'h1);
        set_wb(1'b1, 5'd0, 32'h11111111);
        tick();
        check("wb_r0_wren", 32'(RFWrEn), 32'h0);
        set_wb(1'b0, 5'd0, 32'h0);

        // MD alone
        set_md(1'b1, 5'd7, 32'h12);
        check("md_ready", 32'(MDReady), 32'h1);
        tick();
        set_md(1'b0, 5'd0, 32'h0);
        check("md_busy_set", BusyMask, 32'h80);
        check("md_no_wr_yet", 32'(RFWrEn), 32'h0);
        expect_wr(5'd7, 32'h12);
        tick();
        check("md_busy_clr", BusyMask, 32'h0);

        // Fill: WB busy, three MD results offered
        set_wb(1'b1, 5'd1, 32'h101);
        set_md(1'b1, 5'd10, 32'hA0);
        expect_wr(5'd1, 32'h101);
        tick();
        set_wb(1'b1, 5'd2, 32'h102);
        set_md(1'b1, 5'd11, 32'hB0);
        check("fill_ready1", 32'(MDReady), 32'h1);
        expect_wr(5'd2, 32'h102);
        tick();
        set_wb(1'b1, 5'd3, 32'h103);
        set_md(1'b1, 5'd12, 32'hC0);
        check("fill_full_ready", 32'(MDReady), 32'h0);
        check("fill_busy", BusyMask, 32'h0000_0C00);
        expect_wr(5'd3, 32'h103);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        check("fill_held_ready", 32'(MDReady), 32'h0);
        expect_wr(5'd10, 32'hA0);
        tick();
        check("drain_ready", 32'(MDReady), 32'h1);
        expect_wr(5'd11, 32'hB0);
        tick();
        set_md(1'b0, 5'd0, 32'h0);
        check("drain_busy_c", BusyMask, 32'h0000_1000);
        expect_wr(5'd12, 32'hC0);
        tick();
        tick();
        check("drain_idle_wren", 32'(RFWrEn), 32'h0);
        check("drain_idle_busy", BusyMask, 32'h0);

        // Squash: buffered rd9 overtaken by WB rd9
        set_wb(1'b1, 5'd4, 32'h44);
        set_md(1'b1, 5'd9, 32'h99);
        expect_wr(5'd4, 32'h44);
        tick();
        set_md(1'b0, 5'd0, 32'h0);
        check("sq_busy_set", BusyMask, 32'h0000_0200);
        set_wb(1'b1, 5'd9, 32'h909);
        expect_wr(5'd9, 32'h909);
        tick();
        check("sq_busy_clr", BusyMask, 32'h0);
        set_wb(1'b0, 5'd0, 32'h0);
        tick();
        check("sq_pop_wren", 32'(RFWrEn), 32'h0);
        tick();
        check("sq_after_wren", 32'(RFWrEn), 32'h0);

        // Starvation: valid head loses to WB repeatedly
        set_wb(1'b1, 5'd20, 32'h2000);
        set_md(1'b1, 5'd15, 32'h1500);
        expect_wr(5'd20, 32'h2000);
        tick();
        set_md(1'b0, 5'd0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            set_wb(1'b1, 5'(20 + k), 32'(32'h2000 + k));
            expect_wr(5'(20 + k), 32'(32'h2000 + k));
            tick();
        end
        check("stv_stall_pre", 32'(PipeStall), 32'h0);
        set_wb(1'b1, 5'd25, 32'h2005);
        expect_wr(5'd25, 32'h2005);
        tick();
        check("stv_stall_set", 32'(PipeStall), 32'(GUARD));
        check("stv_busy", BusyMask, 32'h0000_8000);
        set_wb(1'b0, 5'd0, 32'h0);
        expect_wr(5'd15, 32'h1500);
        tick();
        check("stv_stall_hold", 32'(PipeStall), 32'(GUARD));
        check("stv_busy_clr", BusyMask, 32'h0);
        tick();
        check("stv_stall_clr", 32'(PipeStall), 32'h0);
        check("stv_idle_wren", 32'(RFWrEn), 32'h0);

        // Reset with two buffered entries
        set_wb(1'b1, 5'd21, 32'h3021);
        set_md(1'b1, 5'd16, 32'h1600);
        expect_wr(5'd21, 32'h3021);
        tick();
        set_wb(1'b1, 5'd22, 32'h3022);
        set_md(1'b1, 5'd17, 32'h1700);
        expect_wr(5'd22, 32'h3022);
        tick();
        check("mr_busy_two", BusyMask, 32'h0003_0000);
        set_wb(1'b0, 5'd0, 32'h0);
        set_md(1'b0, 5'd0, 32'h0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mr_busy", BusyMask, 32'h0);
        check("mr_wren", 32'(RFWrEn), 32'h0);
        check("mr_ready", 32'(MDReady), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mr_post_wren", 32'(RFWrEn), 32'h0);
        end
        check("mr_post_busy", BusyMask, 32'h0);

        tick();
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
